pulse_scheduler: RTL and testbench
==================================

// Module: pulse_scheduler
// PURPOSE
//  Programmable pulse-train sequencer driven by the shared clock generator.
//  - On a start request, emits num_pulses HIGH windows of high_len cycles on signal, separated by low_len-cycle LOW gaps.
//  - Then raises done for one cycle.
//  - Replaces hand-timed #delay pulse blocks with a synthesizable, cycle-counted controller.
// PARAMETERS
//  LEN_W  8  width of high_len/low_len duration fields (cycles)
//  CNT_W  4  width of num_pulses and pulse_idx
// PORTS
//  clock        in   1      single system clock; all state updates on posedge
//  reset        in   1      synchronous, active-high reset
//  start        in   1      request a new train; sampled only in IDLE
//  high_len     in   LEN_W  HIGH window length in cycles; 0 is treated as 1
//  low_len      in   LEN_W  LOW gap length in cycles; 0 is treated as 1
//  num_pulses   in   CNT_W  pulses per train; 0 means empty train
//  signal       out  1      generated pulse output (registered)
//  busy         out  1      1 while in HIGH or LOW state
//  done         out  1      one-cycle completion strobe
//  pulse_idx    out  CNT_W  index of the current pulse, 0-based (registered)
//  repeat_mode  in   1      [PULSE_SCHED_REPEAT_EN only] continuous train
//  stop         in   1      [PULSE_SCHED_REPEAT_EN only] abort request
// BEHAVIOUR
//  Reset (synchronous)
//   - Forces IDLE; signal=0, busy=0, done=0, pulse_idx=0.
//   - Clears timer and latched configuration.
//   - Asserting reset mid-train aborts it: outputs read 0 on the first edge with reset=1, and no done strobe is issued.
//  FSM states: IDLE, HIGH, LOW, DONE (encoding in the shared header)
//   - IDLE -> HIGH when start=1 and num_pulses!=0. At that edge, latch high_len, low_len and num_pulses.
//   - IDLE -> DONE when start=1 and num_pulses==0. No HIGH window is produced.
//   - HIGH: signal=1 for exactly max(high_len,1) cycles. Then:
//       - more pulses remain -> LOW
//       - last pulse         -> DONE
//   - LOW: signal=0 for exactly max(low_len,1) cycles, then HIGH with pulse_idx+1.
//   - DONE: done=1, signal=0 for one cycle, then IDLE with pulse_idx=0.
//  Latency and timing
//   - start sampled at edge k -> signal=1 from cycle k+1.
//   - Train length (cycles of busy=1): N*H + (N-1)*L.
//   - done occurs in the cycle after the last HIGH cycle.
//  Handshake and input rules
//   - start is ignored outside IDLE (no queuing).
//   - Config inputs are don't-care after latching; changing them mid-train has no effect.
//   - start held high continuously gives back-to-back trains, with one IDLE cycle between DONE and the next HIGH.
//  Timer and count widths
//   - The timer is a LEN_W down-counter, loaded with len-1 on state entry; the state exits when it reaches 0.
//   - No wrap-around is possible.
//   - pulse_idx never exceeds num_pulses-1 in single-shot mode.
// CONFIGURATION
//  Macro PULSE_SCHED_REPEAT_EN
//  - Defined: adds the repeat_mode and stop ports. repeat_mode is latched with the rest of the config at start.
//  - If repeat_mode=1, the last HIGH is followed by LOW and then HIGH again with pulse_idx wrapped to 0. The train never reaches DONE on its own.
//  - stop=1 while busy: the next edge enters DONE (signal=0, done=1), then IDLE. stop is ignored in IDLE and DONE.
//  - stop also aborts single-shot trains.
//  - Undefined: no repeat_mode/stop ports; single-shot behaviour only.
// STRUCTURE
//  - Shared header pulse_sched_defs.v holds:
//      - the state localparams (IDLE=2'd0, HIGH=2'd1, LOW=2'd2, DONE=2'd3)
//      - the default LEN_W and CNT_W values
//  - Sub-module pulse_timer (LEN_W down-counter):
//      - inputs: load, load_val, en
//      - output: zero
//  - pulse_scheduler holds the FSM, the config latches and the output registers.
// TESTING
//  1. high_len=3, low_len=2, num_pulses=2, start pulsed:
//     -> signal pattern 1,1,1,0,0,1,1,1; done=1 on the next cycle; busy high for 8 cycles.
//  2. num_pulses=0, start:
//     -> signal stays 0; done=1 exactly one cycle after start; busy never 1.
//  3. high_len=0, low_len=0, num_pulses=3:
//     -> pattern 1,0,1,0,1, then done; pulse_idx steps 0,1,2.
//  4. Mid-train: change high_len and re-pulse start
//     -> no effect; reset=1 in a HIGH cycle -> signal=0, busy=0, done=0 next cycle.
//  5. start held high with num_pulses=1, high_len=2:
//     -> repeating pattern 1,1,DONE,IDLE; verify one done per train.
//  6. (PULSE_SCHED_REPEAT_EN) repeat_mode=1, num_pulses=2, high_len=1, low_len=1:
//     -> pulse_idx 0,0,1,1,0,...; stop during LOW -> done next cycle, then IDLE.

Source files
------------

// File: rtl/pulse_scheduler_pkg.sv
// Shared state encoding and default widths for the pulse scheduler.
// Used by pulse_scheduler and pulse_timer.
package pulse_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int LEN_W_DEF = 8;
    localparam int CNT_W_DEF = 4;

endpackage

// File: rtl/pulse_scheduler_timer.sv
// pulse_timer: LEN_W down-counter for window timing.
// It loads len-1 on state entry and flags zero when the window ends.
module pulse_timer
    import pulse_scheduler_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [LEN_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - LEN_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/pulse_scheduler.sv
// pulse_scheduler: cycle-counted pulse-train sequencer (IDLE/HIGH/LOW/DONE).
// Define PULSE_SCHED_REPEAT_EN to add the repeat_mode and stop ports.
module pulse_scheduler
    import pulse_scheduler_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] high_len,
    input  logic [LEN_W-1:0] low_len,
    input  logic [CNT_W-1:0] num_pulses,
`ifdef PULSE_SCHED_REPEAT_EN
    input  logic             repeat_mode,
    input  logic             stop,
`endif
    output logic             signal,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pulse_idx
);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] high_q, high_d;
    logic [LEN_W-1:0] low_q, low_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             signal_q, signal_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tmr_load;
    logic [LEN_W-1:0] tmr_val;
    logic             tmr_zero;
    logic             stop_w;
    logic             rpt_w;
    logic             last_w;

`ifdef PULSE_SCHED_REPEAT_EN
    logic rpt_q, rpt_d;
    assign stop_w = stop;
    assign rpt_w  = rpt_q;
`else
    assign stop_w = 1'b0;
    assign rpt_w  = 1'b0;
`endif

    // A zero length still yields a one-cycle window.
    function automatic logic [LEN_W-1:0] len_m1(input logic [LEN_W-1:0] len);
        return (len == '0) ? '0 : len - LEN_W'(1);
    endfunction

    assign last_w = (idx_q == num_q - CNT_W'(1));

    pulse_timer #(.LEN_W(LEN_W)) u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (1'b1),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        high_d   = high_q;
        low_d    = low_q;
        num_d    = num_q;
        idx_d    = idx_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
`ifdef PULSE_SCHED_REPEAT_EN
        rpt_d    = rpt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d = '0;
                    if (num_pulses == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d  = HIGH;
                        high_d   = high_len;
                        low_d    = low_len;
                        num_d    = num_pulses;
`ifdef PULSE_SCHED_REPEAT_EN
                        rpt_d    = repeat_mode;
`endif
                        tmr_load = 1'b1;
                        tmr_val  = len_m1(high_len);
                    end
                end
            end
            HIGH: begin
                if (stop_w) begin
                    state_d = DONE;
                end else if (tmr_zero) begin
                    if (last_w && !rpt_w) begin
                        state_d = DONE;
                    end else begin
                        state_d  = LOW;
                        tmr_load = 1'b1;
                        tmr_val  = len_m1(low_q);
                    end
                end
            end
            LOW: begin
                if (stop_w) begin
                    state_d = DONE;
                end else if (tmr_zero) begin
                    state_d  = HIGH;
                    tmr_load = 1'b1;
                    tmr_val  = len_m1(high_q);
                    idx_d    = last_w ? '0 : idx_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                idx_d   = '0;
            end
            default: state_d = IDLE;
        endcase
        signal_d = (state_d == HIGH);
        busy_d   = (state_d == HIGH) || (state_d == LOW);
        done_d   = (state_d == DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            high_q   <= '0;
            low_q    <= '0;
            num_q    <= '0;
            idx_q    <= '0;
            signal_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef PULSE_SCHED_REPEAT_EN
            rpt_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            high_q   <= high_d;
            low_q    <= low_d;
            num_q    <= num_d;
            idx_q    <= idx_d;
            signal_q <= signal_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef PULSE_SCHED_REPEAT_EN
            rpt_q    <= rpt_d;
`endif
        end
    end

    assign signal    = signal_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pulse_idx = idx_q;

endmodule

// File: tb/tb_pulse_scheduler.sv
// Directed bench for pulse_scheduler; inputs driven and outputs sampled
// on the falling edge, one cycle per step.
module tb_pulse_scheduler;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] high_len;
    logic [7:0] low_len;
    logic [3:0] num_pulses;
    logic       signal;
    logic       busy;
    logic       done;
    logic [3:0] pulse_idx;
`ifdef PULSE_SCHED_REPEAT_EN
    logic       repeat_mode;
    logic       stop;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    pulse_scheduler dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .high_len   (high_len),
        .low_len    (low_len),
        .num_pulses (num_pulses),
`ifdef PULSE_SCHED_REPEAT_EN
        .repeat_mode(repeat_mode),
        .stop       (stop),
`endif
        .signal     (signal),
        .busy       (busy),
        .done       (done),
        .pulse_idx  (pulse_idx)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] p1;
        logic [4:0] p3;
        logic [3:0] p5s;
        logic [3:0] p5d;
        int         ndone;
        p1  = 8'b1110_0111;
        p3  = 5'b10101;
        p5s = 4'b1100;
        p5d = 4'b0010;

        reset      = 1'b1;
        start      = 1'b0;
        high_len   = 8'd0;
        low_len    = 8'd0;
        num_pulses = 4'd0;
`ifdef PULSE_SCHED_REPEAT_EN
        repeat_mode = 1'b0;
        stop        = 1'b0;
`endif
        @(negedge clock);
        @(negedge clock);
        chk1("rst signal", signal, 1'b0);
        chk1("rst busy", busy, 1'b0);
        chk1("rst done", done, 1'b0);
        chkn("rst idx", pulse_idx, 4'd0);
        reset = 1'b0;
        @(negedge clock);

        // Test 1: H=3 L=2 N=2
        high_len = 8'd3; low_len = 8'd2; num_pulses = 4'd2; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk1("t1 signal", signal, p1[7-i]);
            chk1("t1 busy", busy, 1'b1);
            chk1("t1 done", done, 1'b0);
            chkn("t1 idx", pulse_idx, (i < 5) ? 4'd0 : 4'd1);
            @(negedge clock);
        end
        chk1("t1 done strobe", done, 1'b1);
        chk1("t1 done sig", signal, 1'b0);
        chk1("t1 done busy", busy, 1'b0);
        @(negedge clock);
        chk1("t1 done clr", done, 1'b0);
        chkn("t1 idx clr", pulse_idx, 4'd0);

        // Test 2: empty train
        num_pulses = 4'd0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk1("t2 done", done, 1'b1);
        chk1("t2 signal", signal, 1'b0);
        chk1("t2 busy", busy, 1'b0);
        @(negedge clock);
        chk1("t2 done clr", done, 1'b0);
        chk1("t2 busy idle", busy, 1'b0);

        // Test 3: zero lengths behave as one cycle
        high_len = 8'd0; low_len = 8'd0; num_pulses = 4'd3; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk1("t3 signal", signal, p3[4-i]);
            chk1("t3 busy", busy, 1'b1);
            chkn("t3 idx", pulse_idx, 4'(i / 2));
            @(negedge clock);
        end
        chk1("t3 done", done, 1'b1);
        chk1("t3 done sig", signal, 1'b0);
        @(negedge clock);
        chk1("t3 done clr", done, 1'b0);
        @(negedge clock);

        // Test 4: mid-train config change and restart are ignored, then reset
        high_len = 8'd4; low_len = 8'd1; num_pulses = 4'd2; start = 1'b1;
        @(negedge clock);
        high_len = 8'd1;
        for (int i = 1; i <= 6; i++) begin
            chk1("t4 signal", signal, (i != 5));
            chk1("t4 busy", busy, 1'b1);
            chkn("t4 idx", pulse_idx, (i < 6) ? 4'd0 : 4'd1);
            if (i == 2) start = 1'b0;
            if (i < 6) @(negedge clock);
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk1("t4 rst signal", signal, 1'b0);
        chk1("t4 rst busy", busy, 1'b0);
        chk1("t4 rst done", done, 1'b0);
        chkn("t4 rst idx", pulse_idx, 4'd0);
        @(negedge clock);
        chk1("t4 no done", done, 1'b0);
        chk1("t4 idle sig", signal, 1'b0);

        // Test 5: start held high gives back-to-back trains
        high_len = 8'd2; low_len = 8'd5; num_pulses = 4'd1; start = 1'b1;
        ndone = 0;
        @(negedge clock);
        for (int i = 0; i < 12; i++) begin
            chk1("t5 signal", signal, p5s[3 - (i % 4)]);
            chk1("t5 done", done, p5d[3 - (i % 4)]);
            if (done === 1'b1) ndone++;
            if (i == 11) start = 1'b0;
            @(negedge clock);
        end
        chkn("t5 done count", 4'(ndone), 4'd3);
        chk1("t5 stop sig", signal, 1'b0);
        chk1("t5 stop busy", busy, 1'b0);

`ifdef PULSE_SCHED_REPEAT_EN
        // Test 6: repeat mode, then stop in LOW
        high_len = 8'd1; low_len = 8'd1; num_pulses = 4'd2;
        repeat_mode = 1'b1; start = 1'b1;
        @(negedge clock);
        start = 1'b0; repeat_mode = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk1("t6 signal", signal, (i % 2) == 0);
            chk1("t6 busy", busy, 1'b1);
            chk1("t6 done", done, 1'b0);
            chkn("t6 idx", pulse_idx, 4'((i / 2) % 2));
            if (i == 7) stop = 1'b1;
            @(negedge clock);
        end
        stop = 1'b0;
        chk1("t6 stop done", done, 1'b1);
        chk1("t6 stop sig", signal, 1'b0);
        chk1("t6 stop busy", busy, 1'b0);
        @(negedge clock);
        chk1("t6 idle done", done, 1'b0);
        chkn("t6 idle idx", pulse_idx, 4'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
